// File: rtl/ioif_gpio_ctrl_if.sv
// Pad interface for one GPIO pin: controller drives po/oe/pu, pad returns pi.
//   po : pad output value
//   oe : pad output enable
//   pu : pad pull-up enable
//   pi : pad input level, asynchronous to the controller clock
interface ioif;
  logic po;
  logic oe;
  logic pu;
  logic pi;

  // Controller side, named for the pad-ring connection it makes.
  modport drive  (output po, oe, pu, input pi);
  // Generic controller-side view.
  modport master (output po, oe, pu, input pi);
  // Pad-ring side.
  modport slave  (input po, oe, pu, output pi);
endinterface

// File: rtl/ioif_gpio_ctrl.sv
// GPIO pin controller: registered po/oe/pu drive with write/set/clear/toggle
// access, synchronised and optionally debounced pin inputs, and sticky
// per-pin edge interrupt status.
//   clk, resetn                  : clock, asynchronous active-low reset
//   wr_en/wr_op/wr_sel/wr_data   : register update strobe, op, target, value/mask
//   po_q, oe_q, pu_q             : register readback (same as pad drive)
//   db_tick                      : debounce sample strobe
//   pin_in                       : synchronised, debounced pin levels
//   irq_rise_en, irq_fall_en     : per-pin edge enables
//   irq_clr                      : write-1-to-clear for irq_status
//   irq_status, irq              : sticky edge flags and their OR
//   ioifdrv                      : per-pin pad interfaces
module ioif_gpio_ctrl #(
  parameter int unsigned IOC   = 16,
  parameter int unsigned DBCNT = 4,
  parameter int unsigned DBW   = $clog2(DBCNT + 1)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           wr_en,
  input  logic [1:0]     wr_op,
  input  logic [1:0]     wr_sel,
  input  logic [IOC-1:0] wr_data,
  output logic [IOC-1:0] po_q,
  output logic [IOC-1:0] oe_q,
  output logic [IOC-1:0] pu_q,
  input  logic           db_tick,
  output logic [IOC-1:0] pin_in,
  input  logic [IOC-1:0] irq_rise_en,
  input  logic [IOC-1:0] irq_fall_en,
  input  logic [IOC-1:0] irq_clr,
  output logic [IOC-1:0] irq_status,
  output logic           irq,
  ioif.drive             ioifdrv [0:IOC-1]
);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] SEL_PO = 2'b00;
  localparam logic [1:0] SEL_OE = 2'b01;
  localparam logic [1:0] SEL_PU = 2'b10;

  logic [IOC-1:0] pi_w;
  logic [IOC-1:0] s1;
  logic [IOC-1:0] s2;
  logic [IOC-1:0] pin_d;
  logic [IOC-1:0] rise_c;
  logic [IOC-1:0] fall_c;
  logic [IOC-1:0] irq_set_c;

  // Read-modify-write result for one register.
  function automatic logic [IOC-1:0] apply_op(input logic [1:0]     op,
                                              input logic [IOC-1:0] cur,
                                              input logic [IOC-1:0] data);
    logic [IOC-1:0] res;
    res = cur ^ data;
    case (op)
      OP_WR:   res = data;
      OP_SET:  res = cur | data;
      OP_CLR:  res = cur & ~data;
      default: res = cur ^ data;
    endcase
    return res;
  endfunction

  // Pad fan-out and pad input collection.
  for (genvar i = 0; i < IOC; i++) begin : g_pad
    assign ioifdrv[i].po = po_q[i];
    assign ioifdrv[i].oe = oe_q[i];
    assign ioifdrv[i].pu = pu_q[i];
    assign pi_w[i]       = ioifdrv[i].pi;
  end

  // Drive registers; reserved wr_sel leaves all three untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      po_q <= '1;
      oe_q <= '0;
      pu_q <= '1;
    end else if (wr_en) begin
      case (wr_sel)
        SEL_PO:  po_q <= apply_op(wr_op, po_q, wr_data);
        SEL_OE:  oe_q <= apply_op(wr_op, oe_q, wr_data);
        SEL_PU:  pu_q <= apply_op(wr_op, pu_q, wr_data);
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser; idles high to match the pulled-up pad.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= pi_w;
      s2 <= s1;
    end
  end

  if (DBCNT == 0) begin : g_bypass
    // No debounce: one more flop so pin_in is always registered.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) pin_in <= '1;
      else         pin_in <= s2;
    end
  end else begin : g_db
    logic [DBW-1:0] cnt [IOC];

    // Counter tracks ticks seen while s2 disagrees with pin_in; any agreement
    // restarts it, so only DBCNT consecutive disagreeing ticks commit a change.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        pin_in <= '1;
        for (int i = 0; i < IOC; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < IOC; i++) begin
          if (s2[i] == pin_in[i]) begin
            cnt[i] <= '0;
          end else if (db_tick) begin
            if (cnt[i] == DBW'(DBCNT - 1)) begin
              pin_in[i] <= s2[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + DBW'(1);
            end
          end
        end
      end
    end
  end

  assign rise_c    = pin_in & ~pin_d;
  assign fall_c    = ~pin_in & pin_d;
  assign irq_set_c = (rise_c & irq_rise_en) | (fall_c & irq_fall_en);

  // Edge history and sticky status; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pin_d      <= '1;
      irq_status <= '0;
    end else begin
      pin_d      <= pin_in;
      irq_status <= (irq_status & ~irq_clr) | irq_set_c;
    end
  end

  assign irq = |irq_status;

endmodule

// File: doc/ioif_gpio_ctrl.md
# ioif_gpio_ctrl

Parametrised GPIO pin controller that drives an array of `ioif.drive` pad interfaces from registered output, output-enable and pull-up state. Each pin's `pi` return is synchronised, optionally debounced, and edge-detected into sticky interrupt status. It replaces the static null and pass-through tie-offs wherever a core needs software-controlled pins: a peripheral or CSR block writes it, and the pad ring loads it.

## Interface
Parameters:
- `IOC`, 16, number of pins (1..64).
- `DBCNT`, 4, debounce length in `db_tick` periods; 0 = debounce bypassed.
- `DBW`, `$clog2(DBCNT+1)`, debounce counter width (derived; do not override).

Ports:
- `clk` in 1: single clock for all state.
- `resetn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: register write strobe, one cycle per operation.
- `wr_op` in 2: 00 write, 01 set, 10 clear, 11 toggle.
- `wr_sel` in 2: 00 po, 01 oe, 10 pu, 11 reserved (write ignored).
- `wr_data` in IOC: value for op 00; bit mask for ops 01/10/11.
- `po_q`, `oe_q`, `pu_q` out IOC each: register readback, identical to what is driven to pads.
- `db_tick` in 1: debounce sample strobe (prescaled, one cycle wide).
- `pin_in` out IOC: synchronised, debounced pin level.
- `irq_rise_en`, `irq_fall_en` in IOC each: per-pin edge enables.
- `irq_clr` in IOC: write-1-to-clear for `irq_status`.
- `irq_status` out IOC: sticky edge flags.
- `irq` out 1: OR of `irq_status`.
- `ioifdrv` `ioif.drive` [0:IOC-1]: pad interfaces; `po`/`oe`/`pu` are outputs and `pi` is the input.

## Operation
- Reset values: `po_q` all 1, `oe_q` all 0, `pu_q` all 1; sync flops and `pin_in` all 1; debounce counters 0; `irq_status` 0; `irq` 0.
- Pad drive: `ioifdrv[i].po/oe/pu` = `po_q[i]/oe_q[i]/pu_q[i]`. There is no combinational path from `wr_*` to the pads.
- Write ops are applied on the `clk` edge where `wr_en`=1:
  - write: reg ← `wr_data`
  - set: reg ← reg | `wr_data`
  - clear: reg ← reg & ~`wr_data`
  - toggle: reg ← reg ^ `wr_data`
  - Only the register selected by `wr_sel` changes.
- Input path per pin: `pi` → `s1` → `s2`, a 2-flop synchroniser that is always present.
- When `DBCNT`=0: `pin_in` ← `s2` every cycle. The counter is not built.
- When `DBCNT`>0:
  - If `s2` == `pin_in`: counter ← 0.
  - Else, on `db_tick`: if counter == DBCNT-1, then `pin_in` ← `s2` and counter ← 0; otherwise counter += 1.
  - Else, with no tick: counter holds.
  - A glitch shorter than DBCNT ticks never reaches `pin_in`. The counter does not saturate or wrap; it is cleared at DBCNT-1.
- Edge detect: `pin_d` ← `pin_in` every cycle.
  - Rise = `pin_in` & ~`pin_d`; fall = ~`pin_in` & `pin_d`.
  - `irq_status[i]` sets when (rise & `irq_rise_en[i]`) | (fall & `irq_fall_en[i]`).
  - `irq_status[i]` clears on `irq_clr[i]`.
  - Set and clear in the same cycle: set wins.
- Enabling an edge bit does not retroactively flag past edges.
- `irq` is combinational OR of the `irq_status` registers.

## Timing
- Write → pad: `po/oe/pu` change on the same `clk` edge that samples `wr_en`. Pad and readback are visible 1 cycle after the strobe.
- `pi` → `pin_in`, bypass: 3 `clk` edges (s1, s2, pin_in).
- `pi` → `pin_in`, debounced: 2 edges to `s2`, then DBCNT `db_tick`s with `s2` stable. The update occurs on the edge sampling the DBCNT-th tick.
- `pin_in` change → `irq_status` set: 1 edge. → `irq` high: same cycle as `irq_status`.
- `irq_clr` → `irq_status` low: 1 edge.
- Reset mid-operation: `resetn` low asynchronously forces every register to its reset value within the reset assertion, including pending debounce counts and status. Outputs hold those values until the first edge after `resetn` rises.
- Back-to-back `wr_en` is supported at 1 op per cycle; each op uses the register value left by the previous op.

## Test plan
- Reset, IOC=16: after `resetn` release, `po_q`=16'hFFFF, `oe_q`=0, `pu_q`=16'hFFFF, `pin_in`=16'hFFFF, `irq`=0. Every `ioifdrv[i]` reads po=1, oe=0, pu=1.
- Write ops: write oe=16'h00F0, then set 16'h0003, clear 16'h0010, toggle 16'h8001 on consecutive cycles → `oe_q` goes 00F0, 00F3, 00E3, 80E2. A write with `wr_sel`=11 leaves all three registers unchanged.
- Bypass latency (DBCNT=0): drive `pi[3]` 1→0 → `pin_in[3]`=0 exactly 3 edges later. With `irq_fall_en[3]`=1, `irq_status[3]`=1 and `irq`=1 one edge after that.
- Debounce (DBCNT=4, `db_tick` every 8 clk): a 3-tick low pulse on `pi[0]` leaves `pin_in[0]`=1 and the counter returns to 0. A sustained low flips `pin_in[0]`=0 on the 4th tick.
- W1C collision: `irq_status[5]`=1, then assert `irq_clr[5]` in the same cycle a new enabled rise is detected → bit stays 1. Clearing on the next cycle with no edge → 0, and `irq`=0.
- Reset mid-debounce: assert `resetn` low after 2 of 4 ticks with `pi` low → counter 0 and `pin_in`=1. After release, 2 sync edges plus 4 full ticks are needed before `pin_in`=0.
